// File: rtl/uart_tx_arbiter_pkg.sv
// uart_link_pkg: shared types and helpers for the UART transmit arbiter.
//   arb_state_e : arbiter FSM states
//   HDR_MAGIC   : upper nibble of the source-ID header byte
//   hdr_byte()  : builds the header byte for a given requester index
package uart_link_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } arb_state_e;

    localparam logic [3:0] HDR_MAGIC = 4'hA;

    function automatic logic [7:0] hdr_byte(input logic [3:0] id);
        return {HDR_MAGIC, id};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// rr_select: combinational round-robin picker.
//   i_req   : request vector
//   i_ptr   : index with highest priority this cycle
//   o_found : at least one request is set
//   o_idx   : first set index searching upward from i_ptr, wrapping
module rr_select #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic                       o_found,
    output logic [$clog2(NUM_REQ)-1:0] o_idx
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_pos;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (IW + 1)'(k);
            if (w_sum >= (IW + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (IW + 1)'(NUM_REQ);
            end
            w_pos = w_sum[IW-1:0];
            if (i_req[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx byte interface between NUM_REQ
// packet requesters, round-robin per packet, with optional source-ID header
// and a stall watchdog.
//   clk, reset, ena              : clock, sync active-high reset, clock enable
//   req_valid/req_data/req_last  : per-requester byte stream in
//   req_ready                    : per-requester byte accept
//   utx_valid/utx_data/utx_ready : byte stream toward uart_tx
//   busy                         : a packet is in progress
//   grant_id                     : current or most recent grantee
//   abort_pulse                  : watchdog abort indication
//
// state   | meaning
// IDLE    | no grant; pick next requester round-robin
// HEADER  | sending source-ID header byte for grant_id
// PAYLOAD | passing grantee bytes straight through until last
module uart_tx_arbiter
    import uart_link_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int HEADER_EN      = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ena,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          utx_valid,
    output logic [DATA_WIDTH-1:0]         utx_data,
    input  logic                          utx_ready,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          abort_pulse
);
    localparam int IW = $clog2(NUM_REQ);
    // Abort fires on the stall cycle that brings the count to TIMEOUT_CYCLES-1.
    localparam int STALL_LIM = (TIMEOUT_CYCLES >= 2) ? TIMEOUT_CYCLES - 2 : 0;
    localparam int CW        = (STALL_LIM >= 1) ? $clog2(STALL_LIM + 1) : 1;

    arb_state_e      r_state;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   r_grant_id;
    logic [CW-1:0]   r_stall_cnt;
    logic            r_abort;

    logic            w_found;
    logic [IW-1:0]   w_sel;
    logic            w_g_valid;
    logic            w_g_last;
    logic [DATA_WIDTH-1:0] w_g_data;
    logic [IW-1:0]   w_ptr_next;
    logic            w_xfer;
    logic            w_stall;
    logic            w_timeout;

    rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_sel)
    );

    assign w_g_valid  = req_valid[r_grant_id];
    assign w_g_last   = req_last[r_grant_id];
    assign w_g_data   = req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];
    assign w_ptr_next = (r_grant_id == IW'(NUM_REQ - 1)) ? '0 : r_grant_id + IW'(1);

    always_comb begin
        utx_valid = 1'b0;
        utx_data  = '0;
        req_ready = '0;
        if (ena) begin
            case (r_state)
                HEADER: begin
                    utx_valid = 1'b1;
                    utx_data  = DATA_WIDTH'(hdr_byte(4'(r_grant_id)));
                end
                PAYLOAD: begin
                    utx_valid             = w_g_valid;
                    utx_data              = w_g_data;
                    req_ready[r_grant_id] = utx_ready;
                end
                default: ;
            endcase
        end
    end

    assign w_xfer    = utx_valid & utx_ready;
    assign w_stall   = ena & (r_state == PAYLOAD) & ~w_g_valid;
    assign w_timeout = (TIMEOUT_CYCLES > 0) && w_stall && (r_stall_cnt == CW'(STALL_LIM));

    assign busy        = (r_state != IDLE);
    assign grant_id    = r_grant_id;
    // A pulse pending across an ena=0 window is delivered on the next enabled cycle.
    assign abort_pulse = r_abort & ena;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_stall_cnt <= '0;
            r_abort     <= 1'b0;
        end else if (ena) begin
            r_abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_stall_cnt <= '0;
                    if (w_found) begin
                        r_grant_id <= w_sel;
                        r_state    <= (HEADER_EN != 0) ? HEADER : PAYLOAD;
                    end
                end
                HEADER: begin
                    if (w_xfer) begin
                        r_state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (w_xfer) begin
                        r_stall_cnt <= '0;
                        if (w_g_last) begin
                            r_state  <= IDLE;
                            r_rr_ptr <= w_ptr_next;
                        end
                    end else if (w_timeout) begin
                        r_abort     <= 1'b1;
                        r_state     <= IDLE;
                        r_rr_ptr    <= w_ptr_next;
                        r_stall_cnt <= '0;
                    end else if ((TIMEOUT_CYCLES > 0) && w_stall) begin
                        r_stall_cnt <= r_stall_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester packet queues drive the DUT, a
// transaction-level model (owner / header-pending / round-robin pointer)
// predicts every output each cycle, and directed scenarios check the
// observed uart byte stream against fixed sequences.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            reset, ena, utx_ready;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic            utx_valid;
    logic [DW-1:0]   utx_data;
    logic            busy;
    logic [1:0]      grant_id;
    logic            abort_pulse;

    uart_tx_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .HEADER_EN(1), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .ena(ena),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .utx_valid(utx_valid), .utx_data(utx_data), .utx_ready(utx_ready),
        .busy(busy), .grant_id(grant_id), .abort_pulse(abort_pulse)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [8:0] pq [N][$];        // {last, byte} per requester
    int  gap [N];
    bit  stall_inj [N];
    bit  stall_arm [N];
    bit  rnd_gaps;

    int  m_owner, m_ptr, m_gid, m_stalls;
    bit  m_hdr, m_abort;

    logic [7:0] obs [$];
    int  xfer_cyc [$];
    int  cyc_no = 0;
    int  abort_cyc, abort_cnt, busy_cnt;
    int  exp_total;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc_no);
        end
    endtask

    task automatic push_pkt(input int r, input int len, input int b0, input int step);
        for (int j = 0; j < len; j++) begin
            pq[r].push_back({(j == len - 1), 8'(b0 + j * step)});
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_gid = 0; m_stalls = 0;
        m_hdr = 1'b0; m_abort = 1'b0;
        for (int i = 0; i < N; i++) begin
            pq[i].delete();
            gap[i] = 0; stall_inj[i] = 1'b0; stall_arm[i] = 1'b0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (pq[i].size() > 0) && (gap[i] == 0) && !stall_inj[i];
            if (pq[i].size() > 0) begin
                {req_last[i], req_data[i*DW +: DW]} = pq[i][0];
            end else begin
                req_last[i]          = 1'b0;
                req_data[i*DW +: DW] = 8'($urandom);
            end
        end
    endtask

    // One clock: drive, check at negedge, advance model, return at posedge+1.
    task automatic cyc();
        logic       e_uv;
        logic [7:0] e_ud;
        logic [N-1:0] e_rdy;
        logic [8:0] ent;
        int o, pick, idx;
        drive();
        @(negedge clk);
        e_uv = 1'b0; e_ud = 8'h00; e_rdy = '0;
        if (m_owner >= 0 && m_hdr) begin
            e_uv = ena;
            e_ud = 8'hA0 | 8'(m_owner);
        end else if (m_owner >= 0) begin
            e_uv = ena & req_valid[m_owner];
            e_ud = req_data[m_owner*DW +: DW];
            e_rdy[m_owner] = ena & utx_ready;
        end
        chk("busy", busy, m_owner >= 0);
        chk("grant_id", grant_id, m_gid);
        chk("abort_pulse", abort_pulse, m_abort & ena);
        chk("utx_valid", utx_valid, e_uv);
        chk("req_ready", req_ready, e_rdy);
        if (e_uv) chk("utx_data", utx_data, e_ud);

        if (utx_valid === 1'b1 && utx_ready) begin
            obs.push_back(utx_data);
            xfer_cyc.push_back(cyc_no);
        end
        if (abort_pulse === 1'b1) begin
            abort_cnt++;
            abort_cyc = cyc_no;
        end
        if (busy === 1'b1) busy_cnt++;

        for (int i = 0; i < N; i++) if (gap[i] > 0) gap[i]--;

        if (reset) begin
            model_reset();
        end else if (ena) begin
            m_abort = 1'b0;
            if (m_owner < 0) begin
                pick = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (pick < 0 && req_valid[idx]) pick = idx;
                end
                if (pick >= 0) begin
                    m_owner = pick; m_gid = pick; m_hdr = 1'b1; m_stalls = 0;
                end
            end else if (m_hdr) begin
                if (utx_ready) m_hdr = 1'b0;
            end else begin
                o = m_owner;
                if (req_valid[o] && utx_ready) begin
                    ent = pq[o].pop_front();
                    m_stalls = 0;
                    gap[o] = rnd_gaps ? int'($urandom_range(0, 2)) : 0;
                    if (stall_arm[o]) begin
                        stall_inj[o] = 1'b1;
                        stall_arm[o] = 1'b0;
                    end
                    if (ent[8]) begin
                        m_owner = -1;
                        m_ptr   = (o + 1) % N;
                    end
                end else if (!req_valid[o]) begin
                    // Requester has now stalled TMO-1 enabled cycles since its last byte.
                    if (m_stalls + 1 == TMO - 1) begin
                        m_abort = 1'b1;
                        while (pq[o].size() > 0) begin
                            ent = pq[o].pop_front();
                            if (ent[8]) break;
                        end
                        stall_inj[o] = 1'b0;
                        m_owner  = -1;
                        m_ptr    = (o + 1) % N;
                        m_stalls = 0;
                    end else begin
                        m_stalls++;
                    end
                end
            end
        end
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    // pattern=1 drives utx_ready as a repeating 1,0,0,1 sequence.
    task automatic drain(input int max_cyc, input int rdy_pct, input int ena_pct, input int pattern);
        int  n;
        bit  pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < max_cyc) begin
            if (pattern == 1) utx_ready = ((n % 4) == 0) || ((n % 4) == 3);
            else              utx_ready = ($urandom_range(0, 99) < rdy_pct);
            ena = ($urandom_range(0, 99) < ena_pct);
            cyc();
            n++;
            pending = (m_owner >= 0);
            for (int i = 0; i < N; i++) if (pq[i].size() > 0) pending = 1'b1;
        end
        chk("drain_done", !pending, 1);
        ena = 1'b1;
        utx_ready = 1'b1;
    endtask

    task automatic clear_logs();
        obs.delete();
        xfer_cyc.delete();
        abort_cnt = 0;
        busy_cnt  = 0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_utx_valid"}, utx_valid, 0);
        chk({tag, "_utx_data"}, utx_data, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_abort"}, abort_pulse, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
    endtask

    initial begin
        reset = 1'b1; ena = 1'b1; utx_ready = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0;
        rnd_gaps = 1'b0;
        abort_cyc = -1;
        model_reset();
        clear_logs();
        cyc(); cyc();
        reset = 1'b0;
        chk_outputs_zero("reset");

        // Test 1: single packet from requester 1.
        clear_logs();
        push_pkt(1, 3, 8'h11, 8'h11);
        drain(50, 100, 100, 0);
        chk("t1_len", obs.size(), 4);
        if (obs.size() == 4) begin
            chk("t1_b0", obs[0], 8'hA1);
            chk("t1_b1", obs[1], 8'h11);
            chk("t1_b2", obs[2], 8'h22);
            chk("t1_b3", obs[3], 8'h33);
        end
        chk("t1_busy_cycles", busy_cnt, 4);

        // Pointer now 2: requesters 0 and 3 together must serve 3 first.
        clear_logs();
        push_pkt(0, 1, 8'hC0, 0);
        push_pkt(3, 1, 8'hC3, 0);
        drain(50, 100, 100, 0);
        chk("t1b_len", obs.size(), 4);
        if (obs.size() == 4) begin
            chk("t1b_first_hdr", obs[0], 8'hA3);
            chk("t1b_second_hdr", obs[2], 8'hA0);
        end

        // Test 2: requesters 0 and 2 simultaneously after reset.
        reset = 1'b1; cyc(); reset = 1'b0;
        clear_logs();
        push_pkt(0, 2, 8'h01, 1);
        push_pkt(2, 2, 8'h05, 1);
        drain(50, 100, 100, 0);
        chk("t2_len", obs.size(), 6);
        if (obs.size() == 6) begin
            chk("t2_b0", obs[0], 8'hA0);
            chk("t2_b1", obs[1], 8'h01);
            chk("t2_b2", obs[2], 8'h02);
            chk("t2_b3", obs[3], 8'hA2);
            chk("t2_b4", obs[4], 8'h05);
            chk("t2_b5", obs[5], 8'h06);
            chk("t2_idle_gap", xfer_cyc[3] - xfer_cyc[2], 2);
        end

        // Test 3: fairness, 0 re-requests continuously while 3 waits.
        reset = 1'b1; cyc(); reset = 1'b0;
        clear_logs();
        push_pkt(0, 2, 8'h30, 1);
        push_pkt(0, 2, 8'h40, 1);
        push_pkt(3, 2, 8'h50, 1);
        push_pkt(3, 2, 8'h60, 1);
        drain(80, 100, 100, 0);
        chk("t3_len", obs.size(), 12);
        if (obs.size() == 12) begin
            chk("t3_g0", obs[0], 8'hA0);
            chk("t3_g1", obs[3], 8'hA3);
            chk("t3_g2", obs[6], 8'hA0);
            chk("t3_g3", obs[9], 8'hA3);
        end

        // Test 4: utx_ready 1-0-0-1 backpressure.
        clear_logs();
        push_pkt(1, 2, 8'h44, 8'h11);
        drain(60, 0, 100, 1);
        chk("t4_len", obs.size(), 3);
        if (obs.size() == 3) begin
            chk("t4_b0", obs[0], 8'hA1);
            chk("t4_b1", obs[1], 8'h44);
            chk("t4_b2", obs[2], 8'h55);
        end
        chk("t4_no_abort", abort_cnt, 0);

        // Test 5: watchdog; requester 2 stalls after one byte, 3 pending.
        clear_logs();
        abort_cyc = -1;
        push_pkt(2, 3, 8'h77, 1);
        stall_arm[2] = 1'b1;
        push_pkt(3, 1, 8'h99, 0);
        drain(80, 100, 100, 0);
        chk("t5_abort_cnt", abort_cnt, 1);
        chk("t5_len", obs.size(), 4);
        if (obs.size() == 4) begin
            chk("t5_b0", obs[0], 8'hA2);
            chk("t5_b1", obs[1], 8'h77);
            chk("t5_next_hdr", obs[2], 8'hA3);
            chk("t5_b3", obs[3], 8'h99);
            chk("t5_abort_delay", abort_cyc - xfer_cyc[1], 8);
        end

        // Test 6a: reset mid-payload.
        clear_logs();
        push_pkt(0, 4, 8'h10, 8'h10);
        cyc(); cyc(); cyc();
        chk("t6a_busy_before", busy, 1);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk_outputs_zero("t6a");

        // Test 6b: ena low for 5 cycles mid-packet.
        clear_logs();
        push_pkt(1, 3, 8'hB1, 1);
        ena = 1'b1; utx_ready = 1'b1;
        cyc(); cyc(); cyc();
        ena = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        ena = 1'b1;
        drain(50, 100, 100, 0);
        chk("t6b_len", obs.size(), 4);
        if (obs.size() == 4) begin
            chk("t6b_b0", obs[0], 8'hA1);
            chk("t6b_b1", obs[1], 8'hB1);
            chk("t6b_b2", obs[2], 8'hB2);
            chk("t6b_b3", obs[3], 8'hB3);
        end

        // Randomized traffic with gaps, backpressure and clock-enable dropouts.
        reset = 1'b1; cyc(); reset = 1'b0;
        clear_logs();
        rnd_gaps = 1'b1;
        exp_total = 0;
        for (int round = 0; round < 6; round++) begin
            for (int r = 0; r < N; r++) begin
                int npk, len;
                npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 4);
                    push_pkt(r, len, $urandom_range(0, 255), $urandom_range(1, 255));
                    exp_total += len + 1;
                end
            end
            drain(3000, 70, 85, 0);
        end
        chk("rnd_bytes", obs.size(), exp_total);
        chk("rnd_no_abort", abort_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte-stream requesters, such as a register-readback responder, a debug printer and a loopback echo.
- Each requester presents packets: bytes on valid/ready, with the end marked by last.
- The arbiter grants one requester per packet, round-robin, and optionally prefixes each packet with a source-ID header byte.
- A watchdog reclaims the transmitter from a requester that stalls mid-packet.
- Sits between the requester logic and the uart_tx byte interface, inside the uart wrapper domain.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_WIDTH, 8, byte width; must be 8 when HEADER_EN=1.
- HEADER_EN, 1, 1 = emit a header byte before each packet's payload.
- TIMEOUT_CYCLES, 1024, stall limit in enabled cycles; 0 disables the watchdog.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset; synchronous, active-high.
- ena  input  1  clock enable; when low, all registers hold.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  marks the final byte of a packet.
- req_ready  output  NUM_REQ  per-requester byte accept.
- utx_valid  output  1  byte valid toward uart_tx.
- utx_data  output  DATA_WIDTH  byte toward uart_tx.
- utx_ready  input  1  uart_tx accepts a byte (transfer = utx_valid & utx_ready).
- busy  output  1  high whenever state != IDLE.
- grant_id  output  $clog2(NUM_REQ)  current or most recent grantee.
- abort_pulse  output  1  one-cycle pulse when the watchdog aborts a packet.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, stall counter=0. All of req_ready, utx_valid, busy and abort_pulse are 0; utx_data=0.
- States: IDLE, HEADER, PAYLOAD.
- IDLE:
  - Outputs: utx_valid=0, req_ready=0.
  - If any req_valid is high, select the first asserted index searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - On the next edge: grant_id <= selected index; state <= HEADER if HEADER_EN, else PAYLOAD.
  - Grant latency is 1 cycle from req_valid to busy.
- HEADER:
  - utx_valid=1 and utx_data = 8'hA0 | grant_id.
  - utx_valid and utx_data are held stable until utx_ready.
  - On transfer, state <= PAYLOAD.
  - All req_ready are 0 in this state.
- PAYLOAD (combinational pass-through, zero added latency):
  - utx_valid = req_valid[g] and utx_data = req_data[g], where g = grant_id.
  - req_ready[g] = utx_ready; req_ready of every other requester = 0.
  - On a transfer with req_last[g]=1: state <= IDLE and rr_ptr <= (g+1) mod NUM_REQ.
  - A 1-byte packet (last on its first byte) is legal.
- Requester obligation: once req_valid is asserted, data and last are held until accepted. Other requesters' inputs are ignored while they are not granted.
- Watchdog (active only when TIMEOUT_CYCLES>0):
  - The stall counter increments on each enabled PAYLOAD cycle with req_valid[g]=0.
  - It clears on any transfer and on leaving PAYLOAD.
  - When the counter reaches TIMEOUT_CYCLES-1 with valid still low: abort_pulse=1 on the following cycle, state <= IDLE, rr_ptr <= g+1. No trailer byte is sent.
  - uart_tx backpressure (utx_ready=0) never counts as a stall.
- ena=0:
  - All state and counters hold.
  - utx_valid=0, req_ready=0 and abort_pulse=0.
  - On re-enable, the block resumes in the same state with no byte lost or duplicated.
- Simultaneous events:
  - A watchdog expiry and a transfer in the same cycle: the transfer wins and the counter clears.
  - A new req_valid arriving in the cycle a packet ends is handled from IDLE on the next cycle. There is therefore always ≥1 IDLE cycle between packets.
- Reset mid-packet: returns immediately to reset values. Partial bytes already sent are not retracted.
- Fairness: a requester holding valid continuously waits at most NUM_REQ-1 packets before it is granted.

Decomposition:
- Package uart_link_pkg holds:
  - the state enum typedef (IDLE/HEADER/PAYLOAD);
  - HDR_MAGIC = 4'hA;
  - a function hdr_byte(id).
- Sub-module rr_select:
  - combinational round-robin priority picker;
  - inputs: req vector and pointer; outputs: found flag and index;
  - parameterised by NUM_REQ.

Test Plan:
1. Requester 1 sends 3 bytes 0x11, 0x22, 0x33 with last on 0x33, utx_ready tied 1 → uart sees A1, 11, 22, 33; busy high for 4 cycles; rr_ptr becomes 2.
2. Requesters 0 and 2 assert simultaneously with 2-byte packets → order is A0, payload0, then A2, payload2, with one IDLE cycle between them.
3. Requester 0 re-requests continuously while requester 3 is waiting → grants alternate 0, 3, 0, 3; no starvation.
4. utx_ready toggling 1-0-0-1 during HEADER and PAYLOAD → header byte stays stable; no byte is dropped or duplicated; watchdog does not fire.
5. TIMEOUT_CYCLES=8; requester 2 sends one byte then drops valid → abort_pulse exactly 8 cycles after the last transfer; next grant goes to requester 3 if pending.
6. Assert reset mid-PAYLOAD; also hold ena=0 for 5 cycles mid-packet in a separate run → reset gives IDLE with all outputs 0; the ena run resumes and completes the packet intact.
